// File: rtl/issue_select_requester_pkg.sv
// Shared issue-select types: entry state encoding, default block size, index width helper.
`default_nettype none

package issue_select_requester_pkg;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_REQ    = 2'd2,
    ST_ISSUED = 2'd3
  } entry_state_e;

  localparam int DEFAULT_SIZE_SELECT_BLOCK = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/issue_select_requester_onehot_to_index.sv
// OneHotToIndex: one-hot to binary encoder with an exactly-one-bit-set flag.
`default_nettype none

module OneHotToIndex
  import issue_select_requester_pkg::*;
#(
  parameter int N  = DEFAULT_SIZE_SELECT_BLOCK,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  onehot_i,
  output logic [IW-1:0] idx_o,
  output logic          onehot_ok_o
);

  // OR-reduction of set-bit indices; only meaningful when onehot_ok_o is high.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot_i[i]) idx_o = idx_o | IW'(i);
    end
  end

  assign onehot_ok_o = (onehot_i != '0) && ((onehot_i & (onehot_i - N'(1))) == '0);

endmodule

`default_nettype wire

// File: rtl/issue_select_requester.sv
// Requester leaf of the issue select tree: per-entry request state, grant capture and issue index.
`default_nettype none

module issue_select_requester
  import issue_select_requester_pkg::*;
#(
  parameter int  SIZE_SELECT_BLOCK = DEFAULT_SIZE_SELECT_BLOCK,
  localparam int IDX_W             = idx_width(SIZE_SELECT_BLOCK)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush_i,
  input  logic                         alloc_valid_i,
  input  logic [IDX_W-1:0]             alloc_idx_i,
  input  logic                         alloc_ready_i,
  input  logic [SIZE_SELECT_BLOCK-1:0] wakeup_i,
  output logic [SIZE_SELECT_BLOCK-1:0] req_o,
  input  logic [SIZE_SELECT_BLOCK-1:0] grant_i,
  input  logic [SIZE_SELECT_BLOCK-1:0] replay_i,
  input  logic [SIZE_SELECT_BLOCK-1:0] free_i,
  output logic                         issue_valid_o,
  output logic [IDX_W-1:0]             issue_idx_o,
  output logic [IDX_W:0]               free_count_o,
  output logic                         err_o
);

  localparam int N = SIZE_SELECT_BLOCK;

  entry_state_e     state_q [N];
  entry_state_e     state_d [N];
  logic             issue_valid_q, issue_valid_d;
  logic [IDX_W-1:0] issue_idx_q, issue_idx_d;
  logic [IDX_W:0]   free_count_q, free_count_d;
  logic             err_q, err_d;

  logic [N-1:0]     req;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_onehot;
  logic [IDX_W:0]   n_enter, n_leave;

  OneHotToIndex #(
    .N  (N),
    .IW (IDX_W)
  ) u_grant_enc (
    .onehot_i    (grant_i),
    .idx_o       (grant_idx),
    .onehot_ok_o (grant_onehot)
  );

  always_comb begin
    for (int i = 0; i < N; i++) req[i] = (state_q[i] == ST_REQ);
  end

  always_comb begin
    n_enter = '0;
    n_leave = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      if (flush_i)
        state_d[i] = ST_FREE;
      else if (free_i[i] && state_q[i] == ST_ISSUED)
        state_d[i] = ST_FREE;
      else if (replay_i[i] && state_q[i] == ST_ISSUED)
        state_d[i] = ST_REQ;
      else if (grant_i[i] && grant_onehot && state_q[i] == ST_REQ)
        state_d[i] = ST_ISSUED;
      else if (wakeup_i[i] && state_q[i] == ST_WAIT)
        state_d[i] = ST_REQ;
      else if (alloc_valid_i && alloc_idx_i == IDX_W'(i) && state_q[i] == ST_FREE)
        state_d[i] = alloc_ready_i ? ST_REQ : ST_WAIT;

      if (state_d[i] == ST_FREE && state_q[i] != ST_FREE)
        n_enter = n_enter + {{IDX_W{1'b0}}, 1'b1};
      if (state_d[i] != ST_FREE && state_q[i] == ST_FREE)
        n_leave = n_leave + {{IDX_W{1'b0}}, 1'b1};
    end
  end

  // A flush squashes everything in flight, including the error checks for that cycle.
  always_comb begin
    err_d = err_q;
    if (!flush_i) begin
      if ((|(grant_i & ~req)) ||
          ((grant_i != '0) && !grant_onehot) ||
          (alloc_valid_i && state_q[alloc_idx_i] != ST_FREE))
        err_d = 1'b1;
    end
    issue_valid_d = !flush_i && grant_onehot && (|(grant_i & req));
    issue_idx_d   = issue_valid_d ? grant_idx : issue_idx_q;
    free_count_d  = flush_i ? (IDX_W+1)'(N) : (free_count_q + n_enter - n_leave);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) state_q[i] <= ST_FREE;
      issue_valid_q <= 1'b0;
      issue_idx_q   <= '0;
      free_count_q  <= (IDX_W+1)'(N);
      err_q         <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) state_q[i] <= state_d[i];
      issue_valid_q <= issue_valid_d;
      issue_idx_q   <= issue_idx_d;
      free_count_q  <= free_count_d;
      err_q         <= err_d;
    end
  end

  assign req_o         = req;
  assign issue_valid_o = issue_valid_q;
  assign issue_idx_o   = issue_idx_q;
  assign free_count_o  = free_count_q;
  assign err_o         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_issue_select_requester.sv
// Directed bench for issue_select_requester; issue pulses checked by a queue-driven monitor.
`default_nettype none

module tb_issue_select_requester;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          flush_i = 1'b0;
  logic          alloc_valid_i = 1'b0;
  logic [3:0]    alloc_idx_i = '0;
  logic          alloc_ready_i = 1'b0;
  logic [N-1:0]  wakeup_i = '0;
  logic [N-1:0]  grant_i = '0;
  logic [N-1:0]  replay_i = '0;
  logic [N-1:0]  free_i = '0;
  logic [N-1:0]  req_o;
  logic          issue_valid_o;
  logic [3:0]    issue_idx_o;
  logic [4:0]    free_count_o;
  logic          err_o;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  issue_select_requester #(.SIZE_SELECT_BLOCK(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush_i       (flush_i),
    .alloc_valid_i (alloc_valid_i),
    .alloc_idx_i   (alloc_idx_i),
    .alloc_ready_i (alloc_ready_i),
    .wakeup_i      (wakeup_i),
    .req_o         (req_o),
    .grant_i       (grant_i),
    .replay_i      (replay_i),
    .free_i        (free_i),
    .issue_valid_o (issue_valid_o),
    .issue_idx_o   (issue_idx_o),
    .free_count_o  (free_count_o),
    .err_o         (err_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every issue pulse must match the oldest expected index.
  always @(negedge clk) begin
    if (!reset && issue_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue: got idx %0d expected no issue", issue_idx_o);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("sb_issue_idx", 32'(issue_idx_o), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    flush_i = 1'b0;
    alloc_valid_i = 1'b0;
    alloc_ready_i = 1'b0;
    wakeup_i = '0;
    grant_i = '0;
    replay_i = '0;
    free_i = '0;
  endtask

  task automatic alloc(input int idx, input logic rdy);
    alloc_valid_i = 1'b1;
    alloc_idx_i   = 4'(idx);
    alloc_ready_i = rdy;
    tick();
    clear_strobes();
  endtask

  task automatic grant(input logic [N-1:0] g, input int exp_idx);
    grant_i = g;
    if (exp_idx >= 0) exp_q.push_back(exp_idx);
    tick();
    clear_strobes();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_req", 32'(req_o), 32'h0);
    check("rst_issue_valid", 32'(issue_valid_o), 32'h0);
    check("rst_issue_idx", 32'(issue_idx_o), 32'h0);
    check("rst_free_count", 32'(free_count_o), 32'd16);
    check("rst_err", 32'(err_o), 32'h0);

    alloc(3, 1'b1);
    check("alloc3_req", 32'(req_o), 32'h0008);
    check("alloc3_free_count", 32'(free_count_o), 32'd15);

    grant(16'h0008, 3);
    check("g3_valid", 32'(issue_valid_o), 32'h1);
    check("g3_idx", 32'(issue_idx_o), 32'd3);
    check("g3_req", 32'(req_o), 32'h0);
    free_i = 16'h0008;
    tick();
    clear_strobes();
    check("free3_count", 32'(free_count_o), 32'd16);
    check("free3_valid", 32'(issue_valid_o), 32'h0);
    alloc(3, 1'b1);
    check("realloc3_count", 32'(free_count_o), 32'd15);
    check("realloc3_err", 32'(err_o), 32'h0);
    check("realloc3_req", 32'(req_o), 32'h0008);

    alloc(5, 1'b0);
    check("alloc5_req", 32'(req_o), 32'h0008);
    check("alloc5_count", 32'(free_count_o), 32'd14);
    free_i[5] = 1'b1;
    replay_i[5] = 1'b1;
    wakeup_i[3] = 1'b1;
    tick();
    clear_strobes();
    check("ignored_strobes_req", 32'(req_o), 32'h0008);
    check("ignored_strobes_count", 32'(free_count_o), 32'd14);
    check("ignored_strobes_err", 32'(err_o), 32'h0);
    wakeup_i[5] = 1'b1;
    tick();
    clear_strobes();
    check("wake5_req", 32'(req_o), 32'h0028);
    grant(16'h0020, 5);
    check("g5_valid", 32'(issue_valid_o), 32'h1);
    check("g5_idx", 32'(issue_idx_o), 32'd5);
    check("g5_req", 32'(req_o), 32'h0008);
    tick();
    check("g5_pulse_end", 32'(issue_valid_o), 32'h0);
    check("g5_idx_hold", 32'(issue_idx_o), 32'd5);

    alloc(0, 1'b1);
    alloc(15, 1'b1);
    check("a0_15_req", 32'(req_o), 32'h8009);
    check("a0_15_count", 32'(free_count_o), 32'd12);
    grant(16'h0001, 0);
    check("g0_valid", 32'(issue_valid_o), 32'h1);
    check("g0_idx", 32'(issue_idx_o), 32'd0);
    grant(16'h8000, 15);
    check("g15_valid", 32'(issue_valid_o), 32'h1);
    check("g15_idx", 32'(issue_idx_o), 32'd15);
    check("g15_req", 32'(req_o), 32'h0008);
    replay_i = 16'h8000;
    tick();
    clear_strobes();
    check("replay15_req", 32'(req_o), 32'h8008);
    check("replay15_valid", 32'(issue_valid_o), 32'h0);
    grant(16'h8000, 15);
    check("regrant15_valid", 32'(issue_valid_o), 32'h1);
    check("regrant15_req", 32'(req_o), 32'h0008);
    check("regrant15_err", 32'(err_o), 32'h0);

    for (int i = 1; i < 15; i++) begin
      if (i != 3 && i != 5) alloc(i, 1'b1);
    end
    check("full_count", 32'(free_count_o), 32'd0);
    check("full_req", 32'(req_o), 32'h7FDE);
    check("full_err", 32'(err_o), 32'h0);
    flush_i = 1'b1;
    grant(16'h0004, -1);
    check("flush_valid", 32'(issue_valid_o), 32'h0);
    check("flush_req", 32'(req_o), 32'h0);
    check("flush_count", 32'(free_count_o), 32'd16);
    check("flush_err", 32'(err_o), 32'h0);

    alloc(0, 1'b1);
    alloc(1, 1'b1);
    check("a01_req", 32'(req_o), 32'h0003);
    check("a01_count", 32'(free_count_o), 32'd14);
    grant(16'h0003, -1);
    check("multi_err", 32'(err_o), 32'h1);
    check("multi_valid", 32'(issue_valid_o), 32'h0);
    check("multi_req", 32'(req_o), 32'h0003);
    tick();
    check("multi_err_sticky", 32'(err_o), 32'h1);

    grant_i = 16'h0001;
    #2 reset = 1'b1;
    #1;
    check("async_rst_req", 32'(req_o), 32'h0);
    check("async_rst_count", 32'(free_count_o), 32'd16);
    check("async_rst_err", 32'(err_o), 32'h0);
    check("async_rst_valid", 32'(issue_valid_o), 32'h0);
    grant_i = '0;
    #3 reset = 1'b0;
    tick();

    alloc(2, 1'b1);
    check("a2_count", 32'(free_count_o), 32'd15);
    check("a2_err", 32'(err_o), 32'h0);
    alloc(2, 1'b0);
    check("dup_alloc_err", 32'(err_o), 32'h1);
    check("dup_alloc_count", 32'(free_count_o), 32'd15);
    check("dup_alloc_req", 32'(req_o), 32'h0004);

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
